// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: FSM states, memory op codes
// and RV32I load/store funct3 width codes.
package mem_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_WAIT_BEF  = 3'b001,
    S_MEM_REQ   = 3'b011,
    S_SENDING   = 3'b010,
    S_WAIT_SEND = 3'b100
  } state_e;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved op 11 and bubbles never touch memory.
  function automatic logic is_mem(input logic valid, input logic [1:0] op);
    return valid & ((op == OP_LOAD) | (op == OP_STORE));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack port; master is the memory-access stage.
interface mem_access_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_align.sv
// Byte-lane handling: load extraction with sign/zero extension, store lane
// replication and strobe generation. Purely combinational.
module mem_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] sdata,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
  assign rhalf = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    unique case (funct3)
      F3_B:    load_val = {{(XLEN-8){rbyte[7]}}, rbyte};
      F3_BU:   load_val = {{(XLEN-8){1'b0}}, rbyte};
      F3_H:    load_val = {{(XLEN-16){rhalf[15]}}, rhalf};
      F3_HU:   load_val = {{(XLEN-16){1'b0}}, rhalf};
      default: load_val = rdata;
    endcase
  end

  always_comb begin
    unique case (funct3)
      F3_B: begin
        wdata = {(XLEN/8){sdata[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {(XLEN/16){sdata[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = sdata;
        wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: captures an execute payload, performs the load or
// store over the req/ack port and hands the result to write-back.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startSig,
  input  logic               beforePipReadyToSend,
  input  logic               nextPipReadyToRcv,
  input  logic               ex_valid,
  input  logic [REG_IDX-1:0] ex_rd_idx,
  input  logic [XLEN-1:0]    ex_alu_val,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic [1:0]         ex_mem_op,
  input  logic [2:0]         ex_funct3,
  output logic               curPipReadyToRcv,
  output logic               curPipReadyToSend,
  output logic               wb_valid,
  output logic [REG_IDX-1:0] wb_idx,
  output logic [XLEN-1:0]    wb_val,
  output logic               wb_en_valid,
  output logic               wb_en_idx,
  output logic               wb_en_data,
  output logic [REG_IDX-1:0] bp_idx,
  output logic [XLEN-1:0]    bp_val,
  mem_access_if.master       dmem
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [2:0]         f3_q, f3_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    sdata_q, sdata_d;
  logic               wb_valid_q, wb_valid_d;
  logic [REG_IDX-1:0] wb_idx_q, wb_idx_d;
  logic [XLEN-1:0]    wb_val_q, wb_val_d;

  logic            fire_out, capture, mem_ack, is_store, bp_on;
  state_e          cap_st;
  logic [XLEN-1:0] load_val, st_wdata;
  logic [3:0]      st_wstrb;

  assign curPipReadyToSend = (state_q == S_SENDING) | (state_q == S_WAIT_SEND);
  assign fire_out          = curPipReadyToSend & nextPipReadyToRcv;
  assign curPipReadyToRcv  = (state_q == S_WAIT_BEF) | fire_out;
  // startSig forces a capture whenever execute has data, whatever the state.
  assign capture = startSig ? beforePipReadyToSend
                            : (beforePipReadyToSend & curPipReadyToRcv);
  assign cap_st  = is_mem(ex_valid, ex_mem_op) ? S_MEM_REQ : S_SENDING;
  assign mem_ack = (state_q == S_MEM_REQ) & dmem.dmem_ack & ~startSig;
  assign is_store = (op_q == OP_STORE);

  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo  (addr_q[1:0]),
    .funct3   (f3_q),
    .rdata    (dmem.dmem_rdata),
    .sdata    (sdata_q),
    .load_val (load_val),
    .wdata    (st_wdata),
    .wstrb    (st_wstrb)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_val_d   = wb_val_q;

    if (startSig) begin
      state_d = beforePipReadyToSend ? cap_st : S_WAIT_BEF;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_WAIT_BEF: state_d = beforePipReadyToSend ? cap_st : S_WAIT_BEF;
        S_MEM_REQ:  state_d = dmem.dmem_ack ? S_SENDING : S_MEM_REQ;
        S_SENDING, S_WAIT_SEND: begin
          if (fire_out) state_d = beforePipReadyToSend ? cap_st : S_WAIT_BEF;
          else          state_d = S_WAIT_SEND;
        end
        default:    state_d = S_IDLE;
      endcase
    end

    if (capture) begin
      op_d       = is_mem(ex_valid, ex_mem_op) ? ex_mem_op : OP_NONE;
      f3_d       = ex_funct3;
      addr_d     = ex_alu_val;
      sdata_d    = ex_store_data;
      wb_idx_d   = ex_rd_idx;
      wb_val_d   = ex_alu_val;
      wb_valid_d = ex_valid & (ex_mem_op != OP_STORE);
    end else if (mem_ack && op_q == OP_LOAD) begin
      wb_val_d = load_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NONE;
      f3_q       <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_val_q   <= wb_val_d;
    end
  end

  // Store lanes are gated so the bus idles at zero outside a store request.
  assign dmem.dmem_req   = (state_q == S_MEM_REQ);
  assign dmem.dmem_we    = dmem.dmem_req & is_store;
  assign dmem.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata = dmem.dmem_we ? st_wdata : '0;
  assign dmem.dmem_wstrb = dmem.dmem_we ? st_wstrb : 4'b0000;

  assign wb_valid    = wb_valid_q;
  assign wb_idx      = wb_idx_q;
  assign wb_val      = wb_val_q;
  assign wb_en_valid = fire_out;
  assign wb_en_idx   = fire_out;
  assign wb_en_data  = fire_out;

  assign bp_on  = curPipReadyToSend & wb_valid_q & (wb_idx_q != '0);
  assign bp_idx = bp_on ? wb_idx_q : '0;
  assign bp_val = bp_on ? wb_val_q : '0;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RV32I multicycle pipeline, sitting between execute and write-back. It captures one execute result per handshake and performs the load or store against the data memory through a req/ack port. It then presents the destination index and value to the write-back stage through the `wb_*` field/enable interface, using the same ready-to-send/ready-to-receive handshake. It also drives a bypass pair for ALU results while they wait to be sent.

## Interface
- `XLEN`, 32, datapath and address width
- `REG_IDX`, 5, register index width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `startSig`  in  1  one-cycle pipeline start pulse
- `beforePipReadyToSend`  in  1  execute stage has a valid payload
- `nextPipReadyToRcv`  in  1  write-back stage can accept a payload
- `ex_valid`  in  1  payload carries a real instruction (0 = bubble)
- `ex_rd_idx`  in  REG_IDX  destination register
- `ex_alu_val`  in  XLEN  ALU result, or effective address for load/store
- `ex_store_data`  in  XLEN  rs2 value for stores
- `ex_mem_op`  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- `ex_funct3`  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `curPipReadyToRcv`  out  1  this stage accepts an execute payload this cycle
- `curPipReadyToSend`  out  1  payload available to write-back
- `wb_valid`, `wb_idx`, `wb_val`  out  1/REG_IDX/XLEN  payload to write-back
- `wb_en_valid`, `wb_en_idx`, `wb_en_data`  out  1 each  load strobes for write-back registers
- `bp_idx`, `bp_val`  out  REG_IDX/XLEN  bypass to decode; 0/0 when not driving
- `dmem_req`, `dmem_we`  out  1 each  memory request, write enable
- `dmem_addr`  out  XLEN  word-aligned address `{addr[XLEN-1:2],2'b00}`
- `dmem_wdata`, `dmem_wstrb`  out  XLEN/4  lane-shifted store data, byte strobes
- `dmem_ack`  in  1  request complete (read data valid in the same cycle)
- `dmem_rdata`  in  XLEN  raw read word

## Operation
- States: IDLE 000, WAIT_BEF 001, MEM_REQ 011, SENDING 010, WAIT_SEND 100.
- `fire_in = beforePipReadyToSend & curPipReadyToRcv` captures all `ex_*` into internal registers.
- `fire_out = curPipReadyToSend & nextPipReadyToRcv`.
- `curPipReadyToRcv = (state==WAIT_BEF) | fire_out`.
- `curPipReadyToSend = (state==SENDING) | (state==WAIT_SEND)`.
- `wb_en_valid`, `wb_en_idx`, `wb_en_data` all equal `fire_out`. `wb_*` hold captured/loaded values and stay stable from SENDING until `fire_out`.
- Next-state rules:
  - `startSig` overrides the current state: `beforePipReadyToSend` ? capture path : WAIT_BEF.
  - Capture path: `ex_valid & op==load|store` → MEM_REQ; otherwise → SENDING.
  - WAIT_BEF: capture path if `beforePipReadyToSend`, else stay.
  - MEM_REQ: `dmem_ack` → SENDING, else stay.
  - SENDING/WAIT_SEND: on `fire_out`, capture path if `beforePipReadyToSend`, else WAIT_BEF; without `fire_out` → WAIT_SEND.
  - IDLE stays IDLE until `startSig`.
- `dmem_req` = (state==MEM_REQ). Address, data, strobe and `we` come from registers and stay constant while requesting.
- Loads: select the byte/halfword by `addr[1:0]` (`addr[0]` ignored for halfwords, both bits ignored for words), then sign- or zero-extend per funct3. The result is registered into `wb_val` on `dmem_ack`.
- Stores: SB uses strobe `0001<<addr[1:0]` with the byte replicated; SH uses `0011<<{addr[1],0}`; SW uses `1111`. `wb_valid` is forced to 0.
- Non-memory ops: `wb_val = ex_alu_val`, `wb_valid = ex_valid`. Bubbles also force `wb_valid = 0`.
- Bypass: `bp_idx`/`bp_val` are driven when the state is SENDING or WAIT_SEND, `wb_valid = 1` and `wb_idx != 0`; otherwise 0/0.

## Timing
- Reset (async): state IDLE; all payload registers, `wb_*`, `dmem_*` outputs, `bp_*` and ready outputs are 0.
- Non-memory latency: capture edge → SENDING; `curPipReadyToSend` is high the next cycle.
- Load/store latency: 1 cycle plus memory wait. The request is asserted the cycle after capture, and SENDING follows the `dmem_ack` edge. A single-cycle memory gives 2 cycles capture-to-send.
- Back-to-back: `fire_out` and `fire_in` in the same cycle gives continuous throughput with no bubble for non-memory ops.
- `dmem_ack` outside MEM_REQ is ignored.
- Reset during MEM_REQ abandons the request; `dmem_req` drops immediately (async), and a late ack is ignored.
- `startSig` during MEM_REQ discards the in-flight access.

## Structure
- Shared package `mem_access_pkg`: state encodings, `ex_mem_op` codes, funct3 load/store codes.
- One sub-module `mem_align` (combinational): load lane extraction and extension, store lane shift and strobe generation.
- The FSM, payload registers and handshake stay in `mem_access`.

## Test plan
- ALU op (`ex_valid=1`, rd=5, alu=0x1234) with write-back ready → `wb_en_*` pulse one cycle with wb_idx=5, wb_val=0x1234, and bp_idx=5/bp_val=0x1234 during SENDING.
- LB, addr 0x103, rdata 0x80FF_FF00 → dmem_addr=0x100 and wb_val=0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
- SH, addr 0x202, data 0x0000_ABCD → dmem_wstrb=1100, dmem_wdata=0xABCD_xxxx (upper half), wb_valid=0, bp=0/0.
- Load with ack delayed 3 cycles, then write-back not ready 2 cycles → dmem_req high for 4 cycles, state moves to WAIT_SEND, and wb_* stay stable until `fire_out`.
- Assert `rst` mid-MEM_REQ → dmem_req=0 the same cycle, state IDLE; a later ack produces no `wb_en_*`.
- Bubble (`ex_valid=0`) and rd=0 writes → wb_valid reflects `ex_valid`, and bp_idx=0 in both cases.
